receiver: RTL
=============

// Module: receiver
// PURPOSE
//   Serial receiver for the team's 7-bit serial link. Deserialises frames
//   driven by the link transmitter: start(0), parity, 7 data bits LSB first,
//   stop(1); each bit lasts CLKS_PER_BIT clocks. Presents one parallel word
//   plus parity/framing status per frame to downstream logic.
// PARAMETERS
//   CLKS_PER_BIT  4   clocks per serial bit; legal range 2..256 (8-bit counter)
// PORTS
//   clk         in   1  system clock; all logic on posedge
//   rst         in   1  synchronous reset, active-high
//   rx          in   1  serial line; idles high
//   data_out    out  7  last received word; bit0 = first data bit on line
//   out_valid   out  1  one-cycle pulse: frame complete, outputs updated
//   parity_err  out  1  last frame: parity bit != ^data (even parity over 8 bits)
//   frame_err   out  1  last frame: stop bit sampled 0
// BEHAVIOUR
//   Reset: data_out=0, out_valid=0, parity_err=0, frame_err=0, counters=0,
//     state=WAIT_HIGH. Reset mid-frame abandons the frame; no out_valid.
//   rx_s = rx, or its synchronised copy (see CONFIGURATION). HALF = CLKS_PER_BIT/2.
//   States:
//     WAIT_HIGH : stay until rx_s==1 -> IDLE. Blocks a stuck-low line from
//                 being read as a start bit.
//     IDLE      : rx_s==0 -> START_BIT, clk_count=0 (detect cycle = T0).
//     START_BIT : count to HALF; at T0+HALF sample: 0 -> PARITY, count=0;
//                 1 -> IDLE (glitch rejected, no output, no flags).
//     PARITY    : after CLKS_PER_BIT clocks sample rx_s into par_bit.
//     RECV_DATA : 7 samples, one every CLKS_PER_BIT clocks, shifted in LSB first
//                 (bit_index 0..6); after bit 6 -> STOP_BIT.
//     STOP_BIT  : after CLKS_PER_BIT clocks sample stop at T0+HALF+9*CLKS_PER_BIT.
//                 On that edge register data_out, parity_err, frame_err=~stop and
//                 out_valid=1 (visible next cycle, high exactly one cycle).
//                 stop==1 -> IDLE; stop==0 -> WAIT_HIGH (no re-trigger on held low).
//   Every sample is at mid-bit relative to T0. Counter counts 0..CLKS_PER_BIT-1.
//   data_out / error flags hold until the next out_valid; errored frames still
//   pulse out_valid and update data_out.
//   Back-to-back: a start edge in the cycle after the stop sample is accepted
//   (IDLE entered directly), so one idle cycle between frames suffices.
//   rx changes between samples are ignored; no oversampling or voting.
// CONFIGURATION
//   RX_SYNC_EN defined: rx passes through a 2-flop synchroniser (reset to 1)
//     before use; all timing shifts +2 clocks; for asynchronous rx sources.
//   RX_SYNC_EN undefined: rx_s = rx directly; rx must be synchronous to clk
//     (e.g. loopback from the on-chip transmitter).
// TESTING (CLKS_PER_BIT=4, RX_SYNC_EN undefined unless stated)
//   1. Frame 0x2A, parity 1, stop 1 -> one out_valid pulse at T0+38 edge,
//      data_out=0x2A, parity_err=0, frame_err=0.
//   2. Frame 0x55 sent with parity 1 -> data_out=0x55, parity_err=1, frame_err=0.
//   3. Frame 0x7F, stop bit 0, rx held low 20 clks then high -> one out_valid,
//      frame_err=1; no second frame while low; next valid frame 0x01 received ok.
//   4. rx low for 1 clk then high -> no out_valid, flags unchanged, state IDLE.
//   5. rst asserted at data bit 3 of frame 0x33 -> outputs cleared next edge, no
//      out_valid; following frame 0x12 received correctly.
//   6. Loopback from transmitter, words 0x00,0x7F,0x2A with 1 idle clk between
//      -> three out_valid pulses, matching data, no errors; repeat with
//      RX_SYNC_EN defined -> same data, each pulse 2 clks later.

Source files
------------

// File: rtl/receiver.sv
// rtl/receiver.sv - 7-bit serial link receiver (start, parity, 7 data LSB first, stop); optional RX_SYNC_EN input synchroniser
module receiver #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [6:0] data_out,
    output logic       out_valid,
    output logic       parity_err,
    output logic       frame_err
);

    // Last counter value of a full bit period, and of the half period used
    // to land the start-bit check (and so every later sample) at mid-bit.
    localparam logic [7:0] C_LAST      = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] C_HALF_LAST = 8'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        WAIT_HIGH = 3'd0,
        IDLE      = 3'd1,
        START_BIT = 3'd2,
        PARITY    = 3'd3,
        RECV_DATA = 3'd4,
        STOP_BIT  = 3'd5
    } state_t;

    logic       w_rx_s;
    state_t     r_state;
    logic [7:0] r_clk_count;
    logic [2:0] r_bit_index;
    logic [6:0] r_shift;
    logic       r_par_bit;
    logic [6:0] r_data_out;
    logic       r_out_valid;
    logic       r_parity_err;
    logic       r_frame_err;

`ifdef RX_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchroniser for an asynchronous line; resets to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;
`else
    assign w_rx_s = rx;
`endif

    // Frame FSM: finds the start edge, samples each bit at mid-bit, and
    // registers the word and status on the stop-bit sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= WAIT_HIGH;
            r_clk_count  <= 8'd0;
            r_bit_index  <= 3'd0;
            r_shift      <= 7'd0;
            r_par_bit    <= 1'b0;
            r_data_out   <= 7'd0;
            r_out_valid  <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                // A line held low (e.g. after a broken stop bit) must return
                // high before a falling edge may count as a start bit.
                WAIT_HIGH: begin
                    r_clk_count <= 8'd0;
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end

                IDLE: begin
                    r_clk_count <= 8'd0;
                    r_bit_index <= 3'd0;
                    if (!w_rx_s) begin
                        r_state <= START_BIT;
                    end
                end

                // Re-check the line half a bit after the edge; a high level
                // means a glitch, which is dropped without touching outputs.
                START_BIT: begin
                    if (r_clk_count == C_HALF_LAST) begin
                        r_clk_count <= 8'd0;
                        r_state     <= w_rx_s ? IDLE : PARITY;
                    end else begin
                        r_clk_count <= r_clk_count + 8'd1;
                    end
                end

                PARITY: begin
                    if (r_clk_count == C_LAST) begin
                        r_clk_count <= 8'd0;
                        r_par_bit   <= w_rx_s;
                        r_bit_index <= 3'd0;
                        r_state     <= RECV_DATA;
                    end else begin
                        r_clk_count <= r_clk_count + 8'd1;
                    end
                end

                // Data arrives LSB first, so shift in from the top; after the
                // seventh sample the first bit sits in bit 0.
                RECV_DATA: begin
                    if (r_clk_count == C_LAST) begin
                        r_clk_count <= 8'd0;
                        r_shift     <= {w_rx_s, r_shift[6:1]};
                        if (r_bit_index == 3'd6) begin
                            r_state <= STOP_BIT;
                        end else begin
                            r_bit_index <= r_bit_index + 3'd1;
                        end
                    end else begin
                        r_clk_count <= r_clk_count + 8'd1;
                    end
                end

                // Errored frames are still delivered; only the flags differ.
                // A low stop bit leaves the line low, so go wait for high.
                STOP_BIT: begin
                    if (r_clk_count == C_LAST) begin
                        r_clk_count  <= 8'd0;
                        r_data_out   <= r_shift;
                        r_parity_err <= r_par_bit ^ (^r_shift);
                        r_frame_err  <= ~w_rx_s;
                        r_out_valid  <= 1'b1;
                        r_state      <= w_rx_s ? IDLE : WAIT_HIGH;
                    end else begin
                        r_clk_count <= r_clk_count + 8'd1;
                    end
                end

                default: begin
                    r_clk_count <= 8'd0;
                    r_state     <= WAIT_HIGH;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign out_valid  = r_out_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;

endmodule
